// File: rtl/imem_arb_pkg.sv
// Shared types and helpers for the instruction-memory arbiter.
package imem_arb_pkg;

    localparam int INSTR_W = 32;

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Word-aligned and inside the memory footprint.
    function automatic logic addr_ok(input logic [INSTR_W-1:0] addr,
                                     input logic [INSTR_W-1:0] limit_bytes);
        return (addr[1:0] == 2'b00) && (addr < limit_bytes);
    endfunction

endpackage

// File: rtl/imem_arb_perf.sv
// Saturating activity counters for the instruction-memory arbiter.
// Only instantiated when IMEM_ARB_PERF_EN is defined.
module imem_arb_perf (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_acc_i,
    input  logic        load_acc_i,
    input  logic        conflict_i,
    output logic [31:0] fetch_cnt_o,
    output logic [31:0] load_cnt_o,
    output logic [31:0] conflict_cnt_o
);

    logic [31:0] fetch_cnt_q, load_cnt_q, conflict_cnt_q;
    logic [31:0] fetch_cnt_d, load_cnt_d, conflict_cnt_d;

    always_comb begin
        fetch_cnt_d    = fetch_cnt_q;
        load_cnt_d     = load_cnt_q;
        conflict_cnt_d = conflict_cnt_q;
        if (fetch_acc_i && (fetch_cnt_q != '1))
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        if (load_acc_i && (load_cnt_q != '1))
            load_cnt_d = load_cnt_q + 32'd1;
        if (conflict_i && (conflict_cnt_q != '1))
            conflict_cnt_d = conflict_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q    <= '0;
            load_cnt_q     <= '0;
            conflict_cnt_q <= '0;
        end else begin
            fetch_cnt_q    <= fetch_cnt_d;
            load_cnt_q     <= load_cnt_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign fetch_cnt_o    = fetch_cnt_q;
    assign load_cnt_o     = load_cnt_q;
    assign conflict_cnt_o = conflict_cnt_q;

endmodule

// File: rtl/imem_arbiter.sv
// Arbitrates the single-port instruction memory between CPU fetch and the program loader.
// Optional perf counters are enabled by defining IMEM_ARB_PERF_EN.
module imem_arbiter
    import imem_arb_pkg::*;
#(
    parameter int DEPTH        = 32,
    parameter int IDX_W        = $clog2(DEPTH),
    parameter int STARVE_LIMIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fetch_valid,
    output logic             fetch_ready,
    input  logic [31:0]      fetch_addr,
    output logic             fetch_rsp_valid,
    output logic [31:0]      fetch_rsp_data,
    output logic             fetch_rsp_err,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [31:0]      load_addr,
    input  logic [31:0]      load_wdata,
    input  logic             load_last,
    output logic             load_done,
    output logic             load_err,
    output logic             cpu_run,
    output logic             mem_en,
    output logic             mem_we,
    output logic [IDX_W-1:0] mem_index,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata
`ifdef IMEM_ARB_PERF_EN
    ,
    output logic [31:0]      perf_fetch_cnt,
    output logic [31:0]      perf_load_cnt,
    output logic [31:0]      perf_conflict_cnt
`endif
);

    localparam logic [INSTR_W-1:0] LIMIT_BYTES = 32'(DEPTH * 4);
    localparam int                 SW          = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0]      STARVE_MAX  = SW'(STARVE_LIMIT);

    state_e        state_q, state_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          rsp_valid_q, rsp_err_q, done_q, done_err_q;
    logic          fetch_ok, load_ok, force_load, fetch_acc, load_acc;

    assign fetch_ok   = addr_ok(fetch_addr, LIMIT_BYTES);
    assign load_ok    = addr_ok(load_addr, LIMIT_BYTES);
    // A loader that has lost STARVE_LIMIT cycles in a row wins over fetch.
    assign force_load = load_valid && (starve_q == STARVE_MAX);
    assign fetch_acc  = fetch_valid && fetch_ready;
    assign load_acc   = load_valid && load_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_BOOT;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if ((state_q == ST_BOOT) && load_acc && load_last)
            state_d = ST_RUN;
    end

    // Grants are gated by rst_n so nothing is accepted while reset is held.
    always_comb begin
        fetch_ready = 1'b0;
        load_ready  = 1'b0;
        if (rst_n) begin
            if (state_q == ST_BOOT)
                load_ready = 1'b1;
            else if (fetch_valid && !force_load)
                fetch_ready = 1'b1;
            else
                load_ready = 1'b1;
        end
    end

    always_comb begin
        starve_d = '0;
        if ((state_q == ST_RUN) && load_valid && !load_acc)
            starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + 1'b1;
    end

    always_comb begin
        mem_en    = (fetch_acc && fetch_ok) || (load_acc && load_ok);
        mem_we    = load_acc && load_ok;
        mem_index = '0;
        if (mem_en)
            mem_index = load_acc ? load_addr[IDX_W+1:2] : fetch_addr[IDX_W+1:2];
        mem_wdata = mem_we ? load_wdata : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            done_q      <= 1'b0;
            done_err_q  <= 1'b0;
        end else begin
            starve_q    <= starve_d;
            rsp_valid_q <= fetch_acc;
            rsp_err_q   <= fetch_acc && !fetch_ok;
            done_q      <= load_acc;
            done_err_q  <= load_acc && !load_ok;
        end
    end

    assign fetch_rsp_valid = rsp_valid_q;
    assign fetch_rsp_err   = rsp_err_q;
    assign fetch_rsp_data  = (rsp_valid_q && !rsp_err_q) ? mem_rdata : '0;
    assign load_done       = done_q;
    assign load_err        = done_err_q;
    assign cpu_run         = (state_q == ST_RUN);

`ifdef IMEM_ARB_PERF_EN
    imem_arb_perf u_perf (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_acc_i    (fetch_acc),
        .load_acc_i     (load_acc),
        .conflict_i     ((state_q == ST_RUN) && fetch_valid && load_valid),
        .fetch_cnt_o    (perf_fetch_cnt),
        .load_cnt_o     (perf_load_cnt),
        .conflict_cnt_o (perf_conflict_cnt)
    );
`endif

endmodule
